sd_sector_bridge: RTL and testbench
===================================

Name: sd_sector_bridge

Overview:
Byte-stream to sector-buffer bridge that sits directly upstream and downstream of the SD sector dual-port RAM, on its port A. In LOAD mode it writes an incoming byte stream (card/IO-controller side) into the RAM. In UNLOAD mode it reads the RAM and emits the bytes as a stream. Port B stays with the core-side consumer.

Parameters:
ADDRWIDTH, 9, RAM address width; must match the attached RAM.
SECTOR_BYTES, 512, bytes per transfer when cmd_len==0; must be ≤ 2**ADDRWIDTH.

Ports:
clock  in  1  single system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
cmd_start  in  1  one-cycle command strobe; accepted only while busy==0.
cmd_dir  in  1  0=LOAD (stream→RAM), 1=UNLOAD (RAM→stream); sampled with cmd_start.
cmd_base  in  ADDRWIDTH  first RAM address; sampled with cmd_start.
cmd_len  in  ADDRWIDTH+1  byte count; 0 means SECTOR_BYTES; sampled with cmd_start.
cmd_abort  in  1  terminates the transfer in progress.
busy  out  1  high from the cycle after an accepted cmd_start until done.
done  out  1  one-cycle pulse at the end of a transfer (normal or aborted).
aborted  out  1  held high with the done pulse and until the next accepted cmd_start when the transfer ended by abort.
count  out  ADDRWIDTH+1  bytes completed in the current or last transfer.
in_valid / in_data[7:0] / in_ready  in/in/out  1/8/1  LOAD stream; a byte transfers when in_valid&in_ready.
out_valid / out_data[7:0] / out_ready  out/out/in  1/8/1  UNLOAD stream; a byte transfers when out_valid&out_ready.
ram_addr  out  ADDRWIDTH  RAM port-A address.
ram_data  out  8  RAM port-A write data.
ram_wren  out  1  RAM port-A write enable.
ram_q  in  8  RAM port-A read data.

Behaviour:
- RAM model: synchronous read, 1-cycle latency. ram_q reflects the address presented on the previous edge with ram_wren=0. On a write cycle ram_q is not updated.
- Reset (async assert, sync-safe deassert) forces: state IDLE, busy=0, done=0, aborted=0, count=0, in_ready=0, out_valid=0, out_data=0, ram_wren=0, ram_addr=0, ram_data=0.
- FSM states: IDLE, LOAD, RD, CAP, OUT, FIN.
- IDLE: cmd_start latches dir, base, and len (len 0→SECTOR_BYTES), and clears count and aborted. dir=0 → LOAD; dir=1 → RD.
- LOAD: in_ready=1.
  - On each handshake: ram_wren=1, ram_addr=base+count, ram_data=in_data, all registered, so the RAM write lands on the following edge. count increments.
  - When count reaches len, go to FIN. in_ready drops combinationally once count==len, so no extra byte is accepted.
  - Sustained throughput: 1 byte/cycle.
- UNLOAD:
  - RD: drive ram_addr=base+count, ram_wren=0 → CAP.
  - CAP: out_data<=ram_q, out_valid<=1 → OUT.
  - OUT: hold out_data and out_valid stable until out_ready. On the handshake, count++ and out_valid<=0; if count+1==len → FIN, else → RD.
  - Throughput: 1 byte per 3 cycles minimum.
- Address arithmetic is modulo 2**ADDRWIDTH: base+count wraps to 0 past the top.
- FIN: done=1 for exactly one cycle, busy<=0 → IDLE. ram_wren is guaranteed low in FIN.
- cmd_abort (any non-IDLE state, priority over handshakes in the same cycle):
  - The byte offered that cycle is not counted. In LOAD it is not written; in OUT it is not consumed.
  - Go to FIN with aborted=1. in_ready and out_valid drop the next cycle.
- cmd_abort in IDLE is ignored. cmd_start while busy is ignored; no queueing.
- Simultaneous cmd_start in the FIN cycle is ignored; it is accepted from IDLE only.
- Asynchronous reset mid-transfer abandons the transfer with no done pulse. Partially written RAM contents are left as-is.

Test Plan:
1. Reset with in_valid=1 → in_ready=0, ram_wren=0, busy=0, done=0 while reset_n=0 and through the first post-reset edge.
2. LOAD, base=0, len=0, bytes 0x00..0xFF repeated with in_valid held high → 512 writes on consecutive cycles, addresses 0..511; done pulses once; count=512; RAM[n]==n&0xFF.
3. UNLOAD, base=0x1FE, len=4, RAM preloaded 0x1FE=0xA1, 0x1FF=0xA2, 0x000=0xA3, 0x001=0xA4; out_ready randomly toggled → stream A1,A2,A3,A4 (wrap verified); out_data stable while stalled; count=4.
4. LOAD, len=10, abort asserted together with the 4th handshake → exactly 3 RAM writes; done and aborted high; count=3; following cmd_start clears aborted.
5. cmd_start issued during busy and in the FIN cycle → ignored; no second done; a fresh cmd_start from IDLE is accepted.
6. reset_n asserted mid-UNLOAD (count=7) → out_valid drops immediately; no done pulse; a new UNLOAD after release starts at count=0.

Source files
------------

// File: rtl/sd_sector_bridge.sv
// sd_sector_bridge: moves bytes between a ready/valid stream and port A of the
// SD sector RAM. LOAD writes the incoming stream into RAM. UNLOAD reads RAM
// (1-cycle synchronous read) and offers each byte on the output stream.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for cmd_start; the command fields are latched on accept
// LOAD  | accepting stream bytes, one registered RAM write per handshake
// RD    | ram_addr already holds base+count; RAM samples it this cycle
// CAP   | ram_q is valid, so capture it into out_data and raise out_valid
// OUT   | hold the byte until out_ready, then read the next one or finish
// FIN   | one-cycle done pulse; ram_wren is already low here
module sd_sector_bridge #(
  parameter int ADDRWIDTH    = 9,
  parameter int SECTOR_BYTES = 512
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_start,
  input  logic                 cmd_dir,
  input  logic [ADDRWIDTH-1:0] cmd_base,
  input  logic [ADDRWIDTH:0]   cmd_len,
  input  logic                 cmd_abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [ADDRWIDTH:0]   count,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  input  logic                 out_ready,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [7:0]           ram_data,
  output logic                 ram_wren,
  input  logic [7:0]           ram_q
);

  localparam logic [ADDRWIDTH:0] SECTOR_LEN = (ADDRWIDTH+1)'(SECTOR_BYTES);
  localparam logic [ADDRWIDTH:0] ONE        = (ADDRWIDTH+1)'(1);

  typedef enum logic [2:0] {IDLE, LOAD, RD, CAP, OUT, FIN} state_t;

  state_t               state, state_nx;
  logic [ADDRWIDTH-1:0] base_q;
  logic [ADDRWIDTH:0]   len_q;
  logic [ADDRWIDTH:0]   count_inc;

  assign count_inc = count + ONE;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state decode and the status outputs that follow directly from state.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = (state != IDLE);
    done     = (state == FIN);
    case (state)
      IDLE: if (cmd_start) state_nx = cmd_dir ? RD : LOAD;
      LOAD: begin
        // Drops as soon as the last byte is counted so nothing extra slips in.
        in_ready = (count != len_q);
        if (cmd_abort || (count == len_q)) state_nx = FIN;
      end
      RD:  state_nx = cmd_abort ? FIN : CAP;
      CAP: state_nx = cmd_abort ? FIN : OUT;
      OUT: begin
        if (cmd_abort)      state_nx = FIN;
        else if (out_ready) state_nx = (count_inc == len_q) ? FIN : RD;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command latches, byte counter, RAM port-A drive and output stream register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q    <= '0;
      len_q     <= '0;
      count     <= '0;
      aborted   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_wren  <= 1'b0;
    end else begin
      ram_wren <= 1'b0;
      case (state)
        IDLE: if (cmd_start) begin
          base_q   <= cmd_base;
          len_q    <= (cmd_len == '0) ? SECTOR_LEN : cmd_len;
          count    <= '0;
          aborted  <= 1'b0;
          // Preloading the address lets RD present it to the RAM immediately.
          ram_addr <= cmd_base;
        end
        LOAD: begin
          if (cmd_abort) aborted <= 1'b1;
          else if (in_valid && in_ready) begin
            ram_wren <= 1'b1;
            ram_addr <= base_q + count[ADDRWIDTH-1:0];
            ram_data <= in_data;
            count    <= count_inc;
          end
        end
        RD: if (cmd_abort) aborted <= 1'b1;
        CAP: begin
          if (cmd_abort) aborted <= 1'b1;
          else begin
            out_data  <= ram_q;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (cmd_abort) begin
            aborted   <= 1'b1;
            out_valid <= 1'b0;
          end else if (out_ready) begin
            count     <= count_inc;
            out_valid <= 1'b0;
            ram_addr  <= base_q + count_inc[ADDRWIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_bridge.sv
// Bench for sd_sector_bridge: a port-A RAM model, a table of whole transfers
// with hand-computed results, and hand sequences for reset and command races.
module tb_sd_sector_bridge;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cmd_start, cmd_dir, cmd_abort;
  logic [8:0] cmd_base;
  logic [9:0] cmd_len;
  logic       busy, done, aborted;
  logic [9:0] count;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [8:0] ram_addr;
  logic [7:0] ram_data, ram_q;
  logic       ram_wren;

  sd_sector_bridge #(.ADDRWIDTH(9), .SECTOR_BYTES(512)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_base(cmd_base),
    .cmd_len(cmd_len), .cmd_abort(cmd_abort),
    .busy(busy), .done(done), .aborted(aborted), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Port-A RAM: synchronous read, read data not updated on write cycles.
  logic [7:0] mem [0:511];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    else          ram_q <= mem[ram_addr];
  end

  int cyc_no = 0;
  always @(posedge clock) cyc_no <= cyc_no + 1;

  // Monitors sample mid-cycle and log writes, accepted output bytes and pulses.
  logic [8:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int         wr_cyc_q  [$];
  logic [7:0] out_q     [$];
  int   done_cnt = 0, stall_err = 0, fin_wren_err = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clock) begin
    if (ram_wren) begin
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_data);
      wr_cyc_q.push_back(cyc_no);
    end
    if (out_valid && out_ready && !cmd_abort) out_q.push_back(out_data);
    if (done) done_cnt++;
    if (done && ram_wren) fin_wren_err++;
    if (prev_stall && out_valid && out_data !== prev_data) stall_err++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    bit         dir;
    logic [8:0] base;
    logic [9:0] len;
    logic [7:0] seed;      // byte k of the stream is seed+k
    bit         rnd;       // random out_ready
    int         abort_at;  // abort together with this handshake (1-based), 0 none
    int         exp_count;
    bit         exp_ab;
    int         exp_n;     // RAM writes (LOAD) or bytes streamed out (UNLOAD)
  } vec_t;

  function automatic vec_t mk(bit dir, logic [8:0] base, logic [9:0] len,
                              logic [7:0] seed, bit rnd, int abort_at,
                              int exp_count, bit exp_ab, int exp_n);
    vec_t v;
    v.dir = dir; v.base = base; v.len = len; v.seed = seed; v.rnd = rnd;
    v.abort_at = abort_at; v.exp_count = exp_count; v.exp_ab = exp_ab; v.exp_n = exp_n;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int w0, o0, d0, hs, cyc, n, bad;
    bit ab_now, hs_now;
    w0 = wr_addr_q.size(); o0 = out_q.size(); d0 = done_cnt;
    cmd_dir = v.dir; cmd_base = v.base; cmd_len = v.len;
    cmd_start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    cmd_start = 1'b0;
    chk($sformatf("v%0d_start_count", idx), 32'(count), 0);
    chk($sformatf("v%0d_start_aborted", idx), 32'(aborted), 0);
    chk($sformatf("v%0d_start_busy", idx), 32'(busy), 1);
    hs = 0; cyc = 0;
    while (!done && cyc < 3000) begin
      if (!v.dir) begin
        in_valid = 1'b1;
        in_data  = v.seed + 8'(hs);
        ab_now   = (v.abort_at != 0) && (hs + 1 == v.abort_at) && in_ready;
        hs_now   = !ab_now && in_ready;
      end else begin
        out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        ab_now    = (v.abort_at != 0) && (hs + 1 == v.abort_at) && out_valid;
        if (ab_now) out_ready = 1'b1;
        hs_now    = !ab_now && out_valid && out_ready;
      end
      cmd_abort = ab_now;
      tick();
      cmd_abort = 1'b0;
      if (hs_now) hs++;
      cyc++;
    end
    chk($sformatf("v%0d_done_seen", idx), 32'(done), 1);
    chk($sformatf("v%0d_end_count", idx), 32'(count), 32'(v.exp_count));
    chk($sformatf("v%0d_end_aborted", idx), 32'(aborted), 32'(v.exp_ab));
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    chk($sformatf("v%0d_done_pulses", idx), 32'(done_cnt - d0), 1);
    chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 0);
    chk($sformatf("v%0d_aborted_hold", idx), 32'(aborted), 32'(v.exp_ab));
    bad = 0;
    if (!v.dir) begin
      n = wr_addr_q.size() - w0;
      chk($sformatf("v%0d_n_writes", idx), 32'(n), 32'(v.exp_n));
      for (int k = 0; k < n; k++)
        if (wr_addr_q[w0+k] !== 9'(v.base + 9'(k)) || wr_data_q[w0+k] !== v.seed + 8'(k)) bad++;
      chk($sformatf("v%0d_wr_stream", idx), 32'(bad), 0);
      if (n > 1)
        chk($sformatf("v%0d_wr_consec", idx), 32'(wr_cyc_q[w0+n-1] - wr_cyc_q[w0]), 32'(n - 1));
    end else begin
      n = out_q.size() - o0;
      chk($sformatf("v%0d_n_out", idx), 32'(n), 32'(v.exp_n));
      for (int k = 0; k < n; k++)
        if (out_q[o0+k] !== v.seed + 8'(k)) bad++;
      chk($sformatf("v%0d_out_stream", idx), 32'(bad), 0);
    end
  endtask

  vec_t vecs [7];

  initial begin
    int bad, cyc, k, d0, w0;
    bit hs_now;

    vecs[0] = mk(0, 9'h000, 10'd0,  8'h00, 0, 0, 512, 0, 512); // full sector
    vecs[1] = mk(0, 9'h1FE, 10'd4,  8'hA1, 0, 0, 4,   0, 4);   // load across wrap
    vecs[2] = mk(1, 9'h1FE, 10'd4,  8'hA1, 1, 0, 4,   0, 4);   // unload across wrap, stalls
    vecs[3] = mk(0, 9'h010, 10'd10, 8'h50, 0, 4, 3,   1, 3);   // abort on 4th handshake
    vecs[4] = mk(1, 9'h010, 10'd3,  8'h50, 0, 0, 3,   0, 3);   // clears aborted, reads it back
    vecs[5] = mk(1, 9'h100, 10'd5,  8'h00, 1, 3, 2,   1, 2);   // abort beats out_ready
    vecs[6] = mk(0, 9'h020, 10'd1,  8'h7E, 0, 0, 1,   0, 1);   // single byte

    reset_n = 1'b0; cmd_start = 1'b0; cmd_dir = 1'b0; cmd_base = '0; cmd_len = '0;
    cmd_abort = 1'b0; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;

    // Reset with in_valid high, then through the first edge after release.
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_ram_wren", 32'(ram_wren), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 0);
    chk("post_rst_ram_wren", 32'(ram_wren), 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    in_valid = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) begin
        bad = 0;
        for (int a = 0; a < 512; a++) if (mem[a] !== 8'(a)) bad++;
        chk("ram_image_sector", 32'(bad), 0);
      end
    end

    // cmd_start held during busy and during the FIN cycle must be ignored.
    d0 = done_cnt; w0 = wr_addr_q.size();
    cmd_dir = 1'b0; cmd_base = 9'h040; cmd_len = 10'd3; cmd_start = 1'b1;
    tick();
    cmd_dir = 1'b1; cmd_base = 9'h000; cmd_len = 10'd0;
    in_valid = 1'b1; k = 0; cyc = 0;
    while (!done && cyc < 50) begin
      in_data = 8'h30 + 8'(k);
      hs_now = in_ready;
      tick();
      if (hs_now) k++;
      cyc++;
    end
    chk("race_done_seen", 32'(done), 1);
    tick();
    cmd_start = 1'b0; in_valid = 1'b0;
    chk("race_fin_start_ignored", 32'(busy), 0);
    repeat (3) tick();
    chk("race_done_pulses", 32'(done_cnt - d0), 1);
    chk("race_n_writes", 32'(wr_addr_q.size() - w0), 3);
    chk("race_count", 32'(count), 3);
    cmd_dir = 1'b0; cmd_base = 9'h048; cmd_len = 10'd2; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    chk("race_fresh_accept", 32'(busy), 1);
    in_valid = 1'b1; cyc = 0;
    while (!done && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("race_fresh_count", 32'(count), 2);
    in_valid = 1'b0;
    repeat (2) tick();

    // Reset in the middle of an UNLOAD.
    cmd_dir = 1'b1; cmd_base = 9'h000; cmd_len = 10'd20; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0; out_ready = 1'b1; cyc = 0;
    while (count != 10'd7 && cyc < 200) begin
      tick();
      cyc++;
    end
    out_ready = 1'b0; cyc = 0;
    while (!out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("mid_unload_count", 32'(count), 7);
    chk("mid_unload_valid", 32'(out_valid), 1);
    d0 = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    chk("mid_rst_no_done", 32'(done_cnt - d0), 0);
    run_vec(mk(1, 9'h1FE, 10'd4, 8'hA1, 0, 0, 4, 0, 4), 7);

    chk("stall_data_stable", 32'(stall_err), 0);
    chk("fin_ram_wren_low", 32'(fin_wren_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
